reaction_game_ctrl: RTL

//  Sequencer for one reaction-timer round: on a start pulse it waits a pseudo-random delay, turns the LED on,

---
 rtl/reaction_pkg.sv | 35 +++
 rtl/ms_tick_gen.sv | 41 ++++
 rtl/reaction_game_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-timer round sequencer:
//   - state_t       : round sequencer states
//   - STATUS_*      : result status codes presented with the result
//   - LFSR_SEED     : value the delay LFSR restarts from after reset
//   - LFSR_TAPS     : tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - lfsr_step()   : one shift of the delay LFSR
// ---------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        DELAY  = 3'd2,
        REACT  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [1:0] STATUS_OK          = 2'd0;
    localparam logic [1:0] STATUS_FALSE_START = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT     = 2'd2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Bit n-1 is set for tap n, so taps 16,14,13,11 land on bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift left and feed the XOR of the tapped bits into bit 0. A non-zero
    // seed never reaches the all-zero lock-up state with a maximal tap set.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
// Divides the system clock down to a one-cycle millisecond tick.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active high (1 = reset)
//   clr    in   restart the divider; the next tick follows TICK_DIV cycles later
//   tick   out  one-cycle pulse every TICK_DIV clocks
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // The tick is decoded straight from the count. It must not depend on clr:
    // clr is derived from the sequencer's next state, which itself looks at
    // the tick, so gating here would close a combinational loop.
    assign tick = (cnt == LAST);

    // Clearing to zero on the edge a state is entered puts the terminal count,
    // and thus the first tick seen by the sequencer, exactly TICK_DIV edges later.
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_game_ctrl
// Sequences one reaction-timer round: a start edge arms the round, a
// pseudo-random delay runs, the LED lights, and millisecond ticks are counted
// until the button is pressed. False starts (press before the LED) and
// timeouts (no press) are reported through the same result handshake.
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous reset, ACTIVE HIGH despite the name
//   start          in   async level; a rising edge starts a round from IDLE
//   button         in   async level; 1 = pressed
//   led_on         out  high while the player should react
//   busy           out  high whenever a round is in progress or pending
//   result_ms      out  reaction time in ms, stable while result_valid
//   result_status  out  0 = ok, 1 = false start, 2 = timeout
//   result_valid   out  result offered; held until accepted
//   result_ready   in   consumer accepts when valid & ready on a clock edge
// ---------------------------------------------------------------------------
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int          TICK_DIV     = 10000,
    parameter int          DELAY_MIN_MS = 1000,
    parameter logic [15:0] DELAY_MASK   = 16'h07FF,
    parameter int          TIMEOUT_MS   = 999,
    parameter int          TIME_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              button,
    output logic              led_on,
    output logic              busy,
    output logic [TIME_W-1:0] result_ms,
    output logic [1:0]        result_status,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam logic [TIME_W-1:0] TIMEOUT_LIM = TIME_W'(TIMEOUT_MS);

    state_t state;
    state_t state_next;

    logic start_s1, start_s2, start_d;
    logic btn_s1, btn_s2, btn_d;
    logic start_edge;
    logic btn_edge;

    logic [15:0] lfsr;

    logic              tick;
    logic              div_clr;
    logic [TIME_W-1:0] ms_cnt;
    logic [TIME_W-1:0] ms_cnt_next;
    logic [TIME_W-1:0] ms_inc;
    logic [TIME_W-1:0] delay_ms;
    logic [TIME_W-1:0] delay_next;
    logic [TIME_W-1:0] delay_sat;
    logic [31:0]       delay_sum;
    logic [TIME_W-1:0] res_ms_next;
    logic [1:0]        status_next;

    // Edges are taken from the second synchronizer stage against a delayed
    // copy, so an input change is acted on at the third clock edge.
    assign start_edge = start_s2 & ~start_d;
    assign btn_edge   = btn_s2 & ~btn_d;

    // The delay is formed wide and clamped to the counter's full scale, so a
    // parameter set whose maximum delay exceeds TIME_W bits never wraps to a
    // short delay.
    assign delay_sum = 32'(DELAY_MIN_MS) + {16'd0, lfsr & DELAY_MASK};
    assign delay_sat = (delay_sum[31:TIME_W] != '0) ? '1 : delay_sum[TIME_W-1:0];

    // Saturating increment; the sequencer leaves DELAY and REACT before the
    // counter could ever reach full scale, so this only guards against wrap.
    assign ms_inc = (ms_cnt == '1) ? ms_cnt : ms_cnt + TIME_W'(1);

    // Every state change restarts the millisecond divider.
    assign div_clr = (state_next != state);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    // Input synchronizers and the free-running delay LFSR. The LFSR keeps
    // stepping in every state so the delay depends on when the player starts.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_d    <= 1'b0;
            lfsr     <= LFSR_SEED;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            btn_s1   <= button;
            btn_s2   <= btn_s1;
            btn_d    <= btn_s2;
            lfsr     <= lfsr_step(lfsr);
        end
    end

    // State register plus the counters and result fields that the next-state
    // logic computes. The status outputs are decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= IDLE;
            ms_cnt        <= '0;
            delay_ms      <= '0;
            result_ms     <= '0;
            result_status <= STATUS_OK;
            led_on        <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
        end else begin
            state         <= state_next;
            ms_cnt        <= ms_cnt_next;
            delay_ms      <= delay_next;
            result_ms     <= res_ms_next;
            result_status <= status_next;
            led_on        <= (state_next == REACT);
            busy          <= (state_next != IDLE);
            result_valid  <= (state_next == RESULT);
        end
    end

    // Next-state logic. A button edge always beats a tick in the same cycle,
    // so a press coinciding with a tick reports the count before that tick,
    // and a press at the final tick of REACT still counts as a valid reaction.
    always_comb begin
        state_next  = state;
        ms_cnt_next = ms_cnt;
        delay_next  = delay_ms;
        res_ms_next = result_ms;
        status_next = result_status;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = ARM;
                    delay_next = delay_sat;
                end
            end

            // A button held while starting must be released before the delay
            // begins; otherwise releasing and re-pressing would be a false start
            // the player never intended.
            ARM: begin
                if (!btn_s2) begin
                    state_next  = DELAY;
                    ms_cnt_next = '0;
                end
            end

            DELAY: begin
                if (btn_edge) begin
                    state_next  = RESULT;
                    status_next = STATUS_FALSE_START;
                    res_ms_next = '0;
                end else if (tick) begin
                    if (ms_inc >= delay_ms) begin
                        state_next  = REACT;
                        ms_cnt_next = '0;
                    end else begin
                        ms_cnt_next = ms_inc;
                    end
                end
            end

            REACT: begin
                if (btn_edge) begin
                    state_next  = RESULT;
                    status_next = STATUS_OK;
                    res_ms_next = ms_cnt;
                end else if (tick) begin
                    if (ms_inc >= TIMEOUT_LIM) begin
                        state_next  = RESULT;
                        status_next = STATUS_TIMEOUT;
                        res_ms_next = TIMEOUT_LIM;
                        ms_cnt_next = TIMEOUT_LIM;
                    end else begin
                        ms_cnt_next = ms_inc;
                    end
                end
            end

            RESULT: begin
                if (result_valid && result_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
